// File: rtl/sevenseg_capture_if.sv
// Pin-side bundle between a 7-segment display driver and its capture/monitor block.
// master drives the segment and digit lines; slave reports the decoded digits.
interface sevenseg_capture_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [6:0]          seg_i;
  logic [DIGITS-1:0]   dig_i;
  logic [5*DIGITS-1:0] code_o;
  logic [DIGITS-1:0]   err_o;
  logic                upd_o;
  logic [IW-1:0]       upd_idx_o;
  logic                frame_o;

  modport master (
    output seg_i, dig_i,
    input  code_o, err_o, upd_o, upd_idx_o, frame_o
  );

  modport slave (
    input  seg_i, dig_i,
    output code_o, err_o, upd_o, upd_idx_o, frame_o
  );
endinterface

// File: rtl/sevenseg_capture.sv
// Samples multiplexed 7-segment pins, waits for STABLE steady cycles, decodes each digit.
// Capture appears STABLE+2 cycles after the pins settle; no backpressure, pins are sampled every cycle.
module sevenseg_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input logic               clk,
  input logic               rst,
  sevenseg_capture_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t              state;
  logic [SW-1:0]       sync1, sync2, s_prev;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DIGITS-1:0]   seen, seen_nxt, dig_s;
  logic [6:0]          seg_s;
  logic                onehot, chg, capture, known;
  logic [4:0]          dec_code;
  logic [IW-1:0]       idx;
  logic [5*DIGITS-1:0] code_q;
  logic [DIGITS-1:0]   err_q;
  logic                upd_q, frame_q;
  logic [IW-1:0]       upd_idx_q;

  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = {1'b1, 5'd0};
      7'b0110000: decode = {1'b1, 5'd1};
      7'b1101101: decode = {1'b1, 5'd2};
      7'b1111001: decode = {1'b1, 5'd3};
      7'b0110011: decode = {1'b1, 5'd4};
      7'b1011011: decode = {1'b1, 5'd5};
      7'b1011111: decode = {1'b1, 5'd6};
      7'b1110000: decode = {1'b1, 5'd7};
      7'b1111111: decode = {1'b1, 5'd8};
      7'b1110011: decode = {1'b1, 5'd9};
      7'b1110111: decode = {1'b1, 5'd10};
      7'b0011111: decode = {1'b1, 5'd11};
      7'b1001110: decode = {1'b1, 5'd12};
      7'b0111101: decode = {1'b1, 5'd13};
      7'b0000000: decode = {1'b1, 5'd31};
      default:    decode = {1'b0, 5'd0};
    endcase
  endfunction

  assign dig_s  = sync2[SW-1:7];
  assign seg_s  = sync2[6:0];
  assign onehot = $onehot(dig_s);
  assign chg    = (sync2 != s_prev);
  assign {known, dec_code} = decode(seg_s);
  assign seen_nxt = seen | dig_s;

  always_comb begin
    if (chg || !onehot)
      cnt_nxt = CW'(1);
    else if (cnt == CW'(STABLE))
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CW'(1);
  end

  // A held pattern keeps cnt saturated; HELD blocks re-capture until S moves.
  assign capture = onehot && (cnt_nxt == CW'(STABLE)) && ((state != HELD) || chg);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_s[i]) idx = IW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync1     <= '0;
      sync2     <= '0;
      s_prev    <= '0;
      cnt       <= '0;
      seen      <= '0;
      code_q    <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      sync1   <= {bus.dig_i, bus.seg_i};
      sync2   <= sync1;
      s_prev  <= sync2;
      cnt     <= cnt_nxt;
      upd_q   <= capture;
      frame_q <= 1'b0;

      case (state)
        IDLE:    if (onehot) state <= capture ? HELD : TRACK;
        TRACK:   if (!onehot) state <= IDLE;
                 else if (capture) state <= HELD;
        HELD:    if (!onehot) state <= IDLE;
                 else if (chg) state <= capture ? HELD : TRACK;
        default: state <= IDLE;
      endcase

      if (capture) begin
        upd_idx_q <= idx;
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_s[i]) begin
            err_q[i] <= !known;
            if (known) code_q[5*i +: 5] <= dec_code;
          end
        end
        if (&seen_nxt) begin
          frame_q <= 1'b1;
          seen    <= '0;
        end else begin
          seen    <= seen_nxt;
        end
      end
    end
  end

  assign bus.code_o    = code_q;
  assign bus.err_o     = err_q;
  assign bus.upd_o     = upd_q;
  assign bus.upd_idx_o = upd_idx_q;
  assign bus.frame_o   = frame_q;
endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomised and directed bench for sevenseg_capture with a history-based reference model
// feeding a scoreboard queue; a negedge monitor pops and compares every upd_o pulse.
module tb_sevenseg_capture;
  localparam int D  = 4;
  localparam int ST = 3;

  typedef struct packed {
    logic [1:0]  idx;
    logic [19:0] code;
    logic [3:0]  err;
    logic        frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_capture_if #(.DIGITS(D)) bus ();
  sevenseg_capture #(.DIGITS(D), .STABLE(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int frame_cnt = 0;
  exp_t sb[$];

  logic [6:0] pat [15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011,
                           7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b0000000};
  int         pcode [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 31};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: S is the pin value two edges back; a capture happens on the
  // edge where a one-hot S has been identical for exactly ST consecutive edges.
  logic [D+6:0] pipe0, pipe1, v;
  logic [D+6:0] hist[$];
  logic [4:0]   m_code [D];
  logic [D-1:0] m_err;
  logic [D-1:0] m_seen;
  int           run, m_idx, m_c;
  bit           m_known;
  exp_t         e;

  always @(posedge clk) begin
    if (rst) begin
      pipe0 = '0; pipe1 = '0;
      hist.delete();
      sb.delete();
      for (int i = 0; i < D; i++) m_code[i] = '0;
      m_err = '0; m_seen = '0;
    end else begin
      v = pipe1; pipe1 = pipe0; pipe0 = {bus.dig_i, bus.seg_i};
      hist.push_back(v);
      if (hist.size() > ST + 1) void'(hist.pop_front());
      run = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        if (hist[k] == v) run++;
        else break;
      end
      if ($countones(v[D+6:7]) == 1 && run == ST) begin
        m_idx = 0;
        for (int i = 0; i < D; i++) if (v[7+i]) m_idx = i;
        m_known = 0; m_c = 0;
        for (int j = 0; j < 15; j++) if (pat[j] == v[6:0]) begin m_known = 1; m_c = pcode[j]; end
        if (m_known) begin m_code[m_idx] = 5'(m_c); m_err[m_idx] = 1'b0; end
        else m_err[m_idx] = 1'b1;
        m_seen[m_idx] = 1'b1;
        e.idx   = 2'(m_idx);
        e.code  = {m_code[3], m_code[2], m_code[1], m_code[0]};
        e.err   = m_err;
        e.frame = (m_seen == '1);
        if (e.frame) m_seen = '0;
        sb.push_back(e);
      end
    end
  end

  exp_t got;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.upd_o) begin
        upd_cnt++;
        if (bus.frame_o) frame_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_upd: got upd_o=1 idx %0d, required no pulse at %0t", bus.upd_idx_o, $time);
        end else begin
          got = sb.pop_front();
          check("upd_idx", 32'(bus.upd_idx_o), 32'(got.idx));
          check("code_o", 32'(bus.code_o), 32'(got.code));
          check("err_o", 32'(bus.err_o), 32'(got.err));
          check("frame_o", 32'(bus.frame_o), 32'(got.frame));
        end
      end else begin
        check("frame_without_upd", 32'(bus.frame_o), 32'd0);
      end
    end
  end

  task automatic hold(input logic [3:0] dig, input logic [6:0] seg, input int n);
    bus.dig_i = dig;
    bus.seg_i = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic latency(input logic [3:0] dig, input logic [6:0] seg, input string name);
    int n;
    bus.dig_i = dig;
    bus.seg_i = seg;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.upd_o) break;
    end
    check(name, 32'(n), 32'(ST + 2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"},  32'(bus.code_o),    32'd0);
    check({tag, "_err"},   32'(bus.err_o),     32'd0);
    check({tag, "_upd"},   32'(bus.upd_o),     32'd0);
    check({tag, "_idx"},   32'(bus.upd_idx_o), 32'd0);
    check({tag, "_frame"}, 32'(bus.frame_o),   32'd0);
  endtask

  int c0, f0;
  logic [19:0] want;

  initial begin
    bus.dig_i = '0;
    bus.seg_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_released");

    // Single digit, fixed latency, then no repeat while held
    c0 = upd_cnt;
    latency(4'b0001, 7'b1111001, "latency_first");
    check("first_code", 32'(bus.code_o[4:0]), 32'd3);
    check("first_err", 32'(bus.err_o[0]), 32'd0);
    hold(4'b0001, 7'b1111001, 12);
    check("held_single_pulse", 32'(upd_cnt - c0), 32'd1);

    // Walk all digits; the frame completes on digit 3
    f0 = frame_cnt;
    hold(4'b0001, 7'b0110000, 6);
    hold(4'b0010, 7'b1110111, 6);
    hold(4'b0100, 7'b0011111, 6);
    hold(4'b1000, 7'b0000000, 6);
    want = {5'd31, 5'd11, 5'd10, 5'd1};
    check("walk_code", 32'(bus.code_o), 32'(want));
    check("walk_frames", 32'(frame_cnt - f0), 32'd1);

    // Unknown pattern keeps the code, then a good one clears the error
    hold(4'b0100, 7'b1000000, 6);
    check("unknown_err", 32'(bus.err_o[2]), 32'd1);
    check("unknown_keeps_code", 32'(bus.code_o[14:10]), 32'd11);
    hold(4'b0100, 7'b1011011, 6);
    check("recover_code", 32'(bus.code_o[14:10]), 32'd5);
    check("recover_err", 32'(bus.err_o[2]), 32'd0);

    // Glitching segments and invalid digit fields never capture
    c0 = upd_cnt;
    for (int i = 0; i < 10; i++) hold(4'b0001, (i % 2) ? 7'b0110000 : 7'b1111110, 2);
    hold(4'b0011, 7'b1111111, 10);
    hold(4'b0000, 7'b1111111, 10);
    check("glitch_no_upd", 32'(upd_cnt - c0), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] d;
      logic [6:0] s;
      r = $urandom_range(0, 9);
      d = (r == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      s = (r < 3) ? 7'($urandom) : pat[$urandom_range(0, 14)];
      hold(d, s, $urandom_range(1, 6));
    end
    hold(4'b0000, 7'b0000000, 6);

    // Reset in the middle of a counting window
    bus.dig_i = 4'b0010;
    bus.seg_i = 7'b1101101;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    latency(4'b0010, 7'b1101101, "latency_after_reset");
    check("after_reset_code", 32'(bus.code_o[9:5]), 32'd2);
    hold(4'b0010, 7'b1101101, 6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
